traffic_lamp_guard: RTL and testbench

- Downstream stage of the intersection phase controller. Consumes its per-direction one-hot lamp requests (NS, EW) and drives the physical lamp outputs.
- Inserts an all-red clearance interval whenever right-of-way changes direction.
- Holds all-red for a start-up interval after reset.
- Detects illegal or conflicting requests and latches a flashing-yellow fault mode until reset.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/traffic_req_check.sv | 21 ++
 rtl/traffic_lamp_guard.sv | 126 ++++++++++++
 tb/tb_traffic_lamp_guard.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp codes, guard states and direction encodings for the intersection
// controller and its lamp guard.
package traffic_pkg;

  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    CLEAR   = 2'd2,
    FAULT   = 2'd3
  } guard_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    NS   = 2'd1,
    EW   = 2'd2
  } dir_t;

  function automatic logic is_lamp_code(input logic [2:0] v);
    return (v == LAMP_G) || (v == LAMP_Y) || (v == LAMP_R);
  endfunction

endpackage

// File: rtl/traffic_req_check.sv
// Combinational legality check and green-direction decode of the two lamp
// requests coming from the phase controller.
module traffic_req_check
  import traffic_pkg::*;
(
  input  logic [2:0] ns_req,
  input  logic [2:0] ew_req,
  output logic       legal_c,
  output logic       ns_green_c,
  output logic       ew_green_c
);

  // Legal means both one-hot and at least one direction showing red.
  always_comb begin
    ns_green_c = (ns_req == LAMP_G);
    ew_green_c = (ew_req == LAMP_G);
    legal_c    = is_lamp_code(ns_req) && is_lamp_code(ew_req) &&
                 ((ns_req == LAMP_R) || (ew_req == LAMP_R));
  end

endmodule

// File: rtl/traffic_lamp_guard.sv
// Lamp guard: start-up all-red, all-red clearance on direction change, and a
// latched flashing-yellow fault mode for filtered illegal requests.
module traffic_lamp_guard
  import traffic_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 100,
  parameter int unsigned CLR_CYC     = 200,
  parameter int unsigned FAULT_FILT  = 4,
  parameter int unsigned FLASH_HALF  = 500,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns_req,
  input  logic [2:0] ew_req,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       clearing,
  output logic       fault
);

  localparam int unsigned FILT_W = $clog2(FAULT_FILT + 1);

  guard_state_t      state;
  dir_t              last_green;
  logic [CNT_W-1:0]  cnt;
  logic [FILT_W-1:0] filt;

  logic legal_c;
  logic ns_green_c;
  logic ew_green_c;
  dir_t req_dir_c;
  logic filt_full_c;

  traffic_req_check u_req_check (
    .ns_req     (ns_req),
    .ew_req     (ew_req),
    .legal_c    (legal_c),
    .ns_green_c (ns_green_c),
    .ew_green_c (ew_green_c)
  );

  always_comb begin
    req_dir_c = NONE;
    if (ns_green_c)      req_dir_c = NS;
    else if (ew_green_c) req_dir_c = EW;
    filt_full_c = (filt == FILT_W'(FAULT_FILT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STARTUP;
      last_green <= NONE;
      cnt        <= '0;
      filt       <= '0;
      ns_lamp    <= LAMP_R;
      ew_lamp    <= LAMP_R;
      clearing   <= 1'b0;
      fault      <= 1'b0;
    end else if (filt_full_c) begin
      // Only reachable from RUN/CLEAR; the filter is cleared on every other path.
      state    <= FAULT;
      cnt      <= '0;
      filt     <= '0;
      ns_lamp  <= LAMP_Y;
      ew_lamp  <= LAMP_Y;
      clearing <= 1'b0;
      fault    <= 1'b1;
    end else begin
      case (state)
        STARTUP: begin
          if (cnt == CNT_W'(STARTUP_CYC - 1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!legal_c) begin
            filt <= filt + FILT_W'(1);
          end else begin
            filt <= '0;
            if ((req_dir_c != NONE) && (last_green != NONE) && (req_dir_c != last_green)) begin
              state    <= CLEAR;
              cnt      <= '0;
              ns_lamp  <= LAMP_R;
              ew_lamp  <= LAMP_R;
              clearing <= 1'b1;
            end else begin
              ns_lamp <= ns_req;
              ew_lamp <= ew_req;
              if (req_dir_c != NONE) last_green <= req_dir_c;
            end
          end
        end
        CLEAR: begin
          filt <= legal_c ? '0 : filt + FILT_W'(1);
          if (cnt == CNT_W'(CLR_CYC - 1)) begin
            state    <= RUN;
            cnt      <= '0;
            clearing <= 1'b0;
            if (legal_c) begin
              ns_lamp <= ns_req;
              ew_lamp <= ew_req;
              if (req_dir_c != NONE) last_green <= req_dir_c;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FAULT: begin
          if (cnt == CNT_W'(FLASH_HALF - 1)) begin
            cnt     <= '0;
            ns_lamp <= (ns_lamp == LAMP_Y) ? LAMP_OFF : LAMP_Y;
            ew_lamp <= (ew_lamp == LAMP_Y) ? LAMP_OFF : LAMP_Y;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Directed bench for traffic_lamp_guard; observed word is
// {ns_lamp, ew_lamp, clearing, fault}.
module tb_traffic_lamp_guard;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ns_req;
  logic [2:0] ew_req;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       clearing;
  logic       fault;
  logic [7:0] obs;

  int vecs = 0;
  int errs = 0;

  localparam logic [7:0] O_RED   = 8'b100_100_0_0;
  localparam logic [7:0] O_NSG   = 8'b001_100_0_0;
  localparam logic [7:0] O_NSY   = 8'b010_100_0_0;
  localparam logic [7:0] O_CLR   = 8'b100_100_1_0;
  localparam logic [7:0] O_EWG   = 8'b100_001_0_0;
  localparam logic [7:0] O_FON   = 8'b010_010_0_1;
  localparam logic [7:0] O_FOFF  = 8'b000_000_0_1;

  traffic_lamp_guard dut (
    .clk      (clk),
    .rst      (rst),
    .ns_req   (ns_req),
    .ew_req   (ew_req),
    .ns_lamp  (ns_lamp),
    .ew_lamp  (ew_lamp),
    .clearing (clearing),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  assign obs = {ns_lamp, ew_lamp, clearing, fault};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then run through start-up so NS green is on display.
  task automatic run_startup;
    rst = 1'b1; ns_req = 3'b001; ew_req = 3'b100;
    tick(); tick();
    rst = 1'b0;
    repeat (101) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; ns_req = 3'b001; ew_req = 3'b100;
    tick(); tick();
    vecs++;
    if (obs !== O_RED) begin
      errs++;
      $display("FAIL reset_state: got %b want %b", obs, O_RED);
    end
  endtask

  task automatic test_startup;
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      vecs++;
      if (obs !== O_RED) begin
        errs++;
        $display("FAIL startup_hold cyc %0d: got %b want %b", k, obs, O_RED);
      end
    end
    tick();
    vecs++;
    if (obs !== O_NSG) begin
      errs++;
      $display("FAIL startup_release: got %b want %b", obs, O_NSG);
    end
  endtask

  task automatic test_clearance;
    ns_req = 3'b010; ew_req = 3'b100;
    tick();
    vecs++;
    if (obs !== O_NSY) begin
      errs++;
      $display("FAIL clr_yellow: got %b want %b", obs, O_NSY);
    end
    ns_req = 3'b100; ew_req = 3'b001;
    for (int k = 0; k < 200; k++) begin
      tick();
      vecs++;
      if (obs !== O_CLR) begin
        errs++;
        $display("FAIL clr_allred cyc %0d: got %b want %b", k, obs, O_CLR);
      end
    end
    tick();
    vecs++;
    if (obs !== O_EWG) begin
      errs++;
      $display("FAIL clr_ew_green: got %b want %b", obs, O_EWG);
    end
  endtask

  task automatic test_same_dir;
    run_startup();
    ns_req = 3'b010; ew_req = 3'b100;
    tick();
    vecs++;
    if (obs !== O_NSY) begin
      errs++;
      $display("FAIL same_dir_yellow: got %b want %b", obs, O_NSY);
    end
    ns_req = 3'b001;
    tick();
    vecs++;
    if (obs !== O_NSG) begin
      errs++;
      $display("FAIL same_dir_green: got %b want %b", obs, O_NSG);
    end
    tick();
    vecs++;
    if (obs !== O_NSG) begin
      errs++;
      $display("FAIL same_dir_hold: got %b want %b", obs, O_NSG);
    end
  endtask

  task automatic test_glitch_filter;
    run_startup();
    ns_req = 3'b001; ew_req = 3'b001;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (obs !== O_NSG) begin
        errs++;
        $display("FAIL glitch3_hold cyc %0d: got %b want %b", k, obs, O_NSG);
      end
    end
    ns_req = 3'b010; ew_req = 3'b100;
    tick();
    vecs++;
    if (obs !== O_NSY) begin
      errs++;
      $display("FAIL glitch_recover: got %b want %b", obs, O_NSY);
    end
    ns_req = 3'b001; ew_req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (obs !== O_NSY) begin
        errs++;
        $display("FAIL glitch4_hold cyc %0d: got %b want %b", k, obs, O_NSY);
      end
    end
    ns_req = 3'b100; ew_req = 3'b100;
    tick();
    vecs++;
    if (obs !== O_FON) begin
      errs++;
      $display("FAIL glitch_fault_entry: got %b want %b", obs, O_FON);
    end
  endtask

  // Continues from the fault entry edge left by test_glitch_filter.
  task automatic test_fault_flash;
    ns_req = 3'b001; ew_req = 3'b100;
    for (int k = 1; k < 500; k++) begin
      tick();
      vecs++;
      if (obs !== O_FON) begin
        errs++;
        $display("FAIL flash_on1 cyc %0d: got %b want %b", k, obs, O_FON);
      end
    end
    for (int k = 0; k < 500; k++) begin
      tick();
      vecs++;
      if (obs !== O_FOFF) begin
        errs++;
        $display("FAIL flash_off cyc %0d: got %b want %b", k, obs, O_FOFF);
      end
    end
    ns_req = 3'b100; ew_req = 3'b001;
    for (int k = 0; k < 500; k++) begin
      tick();
      vecs++;
      if (obs !== O_FON) begin
        errs++;
        $display("FAIL flash_on2 cyc %0d: got %b want %b", k, obs, O_FON);
      end
    end
    tick();
    vecs++;
    if (obs !== O_FOFF) begin
      errs++;
      $display("FAIL flash_off2: got %b want %b", obs, O_FOFF);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (obs !== O_RED) begin
      errs++;
      $display("FAIL fault_reset: got %b want %b", obs, O_RED);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_clear;
    run_startup();
    ns_req = 3'b100; ew_req = 3'b001;
    tick();
    repeat (49) tick();
    vecs++;
    if (obs !== O_CLR) begin
      errs++;
      $display("FAIL midclr_clearing: got %b want %b", obs, O_CLR);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (obs !== O_RED) begin
      errs++;
      $display("FAIL midclr_reset: got %b want %b", obs, O_RED);
    end
    rst = 1'b0; ns_req = 3'b001; ew_req = 3'b100;
    for (int k = 1; k <= 100; k++) begin
      tick();
      vecs++;
      if (obs !== O_RED) begin
        errs++;
        $display("FAIL midclr_startup cyc %0d: got %b want %b", k, obs, O_RED);
      end
    end
    tick();
    vecs++;
    if (obs !== O_NSG) begin
      errs++;
      $display("FAIL midclr_release: got %b want %b", obs, O_NSG);
    end
  endtask

  task automatic test_non_onehot;
    ns_req = 3'b011; ew_req = 3'b100;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (obs !== O_NSG) begin
        errs++;
        $display("FAIL nonhot_hold cyc %0d: got %b want %b", k, obs, O_NSG);
      end
    end
    tick();
    vecs++;
    if (obs !== O_FON) begin
      errs++;
      $display("FAIL nonhot_fault: got %b want %b", obs, O_FON);
    end
  endtask

  initial begin
    rst = 1'b1; ns_req = 3'b100; ew_req = 3'b100;
    test_reset();
    test_startup();
    test_clearance();
    test_same_dir();
    test_glitch_filter();
    test_fault_flash();
    test_reset_mid_clear();
    test_non_onehot();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
